bram_dual_port: RTL and testbench
=================================

Name: bram_dual_port

Overview:
- Parametrised true dual-port block RAM: two independent read/write ports (A, B) on one clock.
- Adds per-byte write enables, a selectable read-during-write mode, an optional second output register stage and a post-reset clear engine.
- Drop-in memory for processor instruction/data stores and shared buffers where two masters need concurrent access.

Parameters:
RAM_WIDTH, 32, data word width in bits; must be a multiple of 8.
RAM_ADDR_BITS, 12, address width; depth = 2**RAM_ADDR_BITS words.
READ_LATENCY, 1, 1 = data one cycle after request; 2 = extra output register stage.
RDW_MODE, 0, same-port read-during-write: 0 = READ_FIRST (old data), 1 = WRITE_FIRST (new data).

Ports:
clock  in  1  single clock, all logic on rising edge.
reset  in  1  asynchronous, active-high; resets FSM, valids and output registers (not array contents).
busy  out  1  high while reset is asserted or the clear engine runs; port requests are ignored while high.
enable_a  in  1  port A request strobe.
write_enable_a  in  RAM_WIDTH/8  port A byte write enables; all zero = read.
address_a  in  RAM_ADDR_BITS  port A word address.
input_data_a  in  RAM_WIDTH  port A write data.
output_data_a  out  RAM_WIDTH  port A read data (registered).
valid_a  out  1  output_data_a holds the result of an accepted request.
enable_b, write_enable_b, address_b, input_data_b, output_data_b, valid_b: same as port A, for port B.

Behaviour:
- Reset values: output_data_a/b = 0, valid_a/b = 0, busy = 1, clear address counter = 0, FSM = CLEAR.
- FSM states:
  - CLEAR: on each cycle after reset deasserts, writes all-zero words at counter 0..2**RAM_ADDR_BITS-1, one word per cycle.
  - CLEAR leaves to READY after the last address is written; busy falls in the same cycle READY is entered.
  - CLEAR therefore lasts exactly 2**RAM_ADDR_BITS cycles.
  - READY holds until reset.
- Reset asserted mid-clear: FSM returns to CLEAR with counter 0; the sweep restarts from the beginning after deassertion.
- Accepted request: enable_x high while busy low.
  - Requests while busy have no effect on memory and produce no valid.
- Writes: byte lane i (bits 8i+7:8i) is written only when write_enable_x[i] = 1; other lanes keep their contents.
- Reads: every accepted request (read or write) updates output_data_x.
  - READ_FIRST: output shows the pre-write word.
  - WRITE_FIRST: output shows the merged post-write word.
- Latency: valid_x and output_data_x appear READ_LATENCY cycles after the request edge.
  - valid_x is a single-cycle pulse per accepted request; back-to-back requests give continuous valid.
- Idle port: output_data_x holds its last value; valid_x = 0.
- Cross-port collisions (same address, same cycle):
  - Both write: port A's enabled bytes win; bytes enabled only on B take B's data.
  - One writes, other reads: the reader returns the old word (READ_FIRST semantics regardless of RDW_MODE).
- Address wrap: no wrap logic needed; full address range valid, no out-of-range case.
- Array inferred as block RAM (RAM_STYLE block); no reset applied to the array.

Optional Feature:
BRAM_PARITY_EN
- Defined:
  - One even-parity bit stored per byte lane, computed from write data on each lane write (the clear engine writes parity 0).
  - Extra outputs parity_error_a and parity_error_b (1 bit each, reset 0) assert with valid_x when any byte's recomputed parity mismatches its stored bit.
  - Extra input parity_inject (1 bit): while high, written parity bits are inverted, for test.
- Not defined: no parity storage, no parity_error_x outputs, no parity_inject input; array width = RAM_WIDTH.

Test Plan:
- Clear sweep: RAM_ADDR_BITS=4; assert reset, deassert -> busy high exactly 16 cycles then low; reads of addresses 0..15 return 0x00000000.
- Byte enables: write 0xAABBCCDD to addr 3 with write_enable_a=4'b1111, then 0x11223344 with 4'b0101 -> read addr 3 returns 0xAA22CC44, valid_a after 1 cycle (READ_LATENCY=1) or 2 cycles (READ_LATENCY=2).
- RDW mode: addr 5 holds 0x1; same-port write 0x2 -> output_data_a = 0x1 with RDW_MODE=0, 0x2 with RDW_MODE=1.
- Collision: same cycle, A writes 0x000000FF (all bytes), B writes 0xFFFFFF00 (all bytes) to addr 7 -> addr 7 reads 0x000000FF; A reads / B writes 0x5 to addr 8 (old 0x0) -> A returns 0x0, later read returns 0x5.
- Reset mid-clear: reset pulse at clear cycle 9 -> sweep restarts, busy high 16 further cycles; requests issued while busy -> no valid, memory unchanged.
- BRAM_PARITY_EN: write 0x01020304 with parity_inject=1, read back -> parity_error_a=1 with valid_a; rewrite with inject=0 -> parity_error_a=0.

Source files
------------

// File: rtl/bram_dual_port.sv
// True dual-port block RAM with byte enables, selectable read-during-write, optional
// second output stage and a post-reset clear sweep. Define BRAM_PARITY_EN for per-byte parity.
module bram_dual_port #(
  parameter int RAM_WIDTH     = 32,
  parameter int RAM_ADDR_BITS = 12,
  parameter int READ_LATENCY  = 1,
  parameter int RDW_MODE      = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic                     busy,
  input  logic                     enable_a,
  input  logic [RAM_WIDTH/8-1:0]   write_enable_a,
  input  logic [RAM_ADDR_BITS-1:0] address_a,
  input  logic [RAM_WIDTH-1:0]     input_data_a,
  output logic [RAM_WIDTH-1:0]     output_data_a,
  output logic                     valid_a,
`ifdef BRAM_PARITY_EN
  input  logic                     parity_inject,
  output logic                     parity_error_a,
  output logic                     parity_error_b,
`endif
  input  logic                     enable_b,
  input  logic [RAM_WIDTH/8-1:0]   write_enable_b,
  input  logic [RAM_ADDR_BITS-1:0] address_b,
  input  logic [RAM_WIDTH-1:0]     input_data_b,
  output logic [RAM_WIDTH-1:0]     output_data_b,
  output logic                     valid_b
);

  localparam int NB    = RAM_WIDTH / 8;
  localparam int DEPTH = 2 ** RAM_ADDR_BITS;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                   state;
  logic [RAM_ADDR_BITS-1:0] clear_count;
  logic                     clearing;
  logic                     accept_a, accept_b;
  logic [RAM_WIDTH-1:0]     old_a, old_b, merged_a, merged_b, read_a, read_b;

  (* ram_style = "block" *) logic [RAM_WIDTH-1:0] mem [DEPTH];

  function automatic logic [RAM_WIDTH-1:0] merge_bytes(input logic [RAM_WIDTH-1:0] old_word,
                                                       input logic [RAM_WIDTH-1:0] new_word,
                                                       input logic [NB-1:0]        lanes);
    merge_bytes = old_word;
    for (int i = 0; i < NB; i++)
      if (lanes[i]) merge_bytes[8*i +: 8] = new_word[8*i +: 8];
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= CLEAR;
      clear_count <= '0;
      busy        <= 1'b1;
    end else if (state == CLEAR) begin
      clear_count <= clear_count + 1'b1;
      if (clear_count == '1) begin
        state <= READY;
        busy  <= 1'b0;
      end
    end
  end

  assign clearing = (state == CLEAR) && !reset;
  assign accept_a = enable_a && !busy;
  assign accept_b = enable_b && !busy;

  // Reads sample the array before this edge's writes, so a cross-port reader always sees old data
  assign old_a    = mem[address_a];
  assign old_b    = mem[address_b];
  assign merged_a = merge_bytes(old_a, input_data_a, write_enable_a);
  assign merged_b = merge_bytes(old_b, input_data_b, write_enable_b);
  assign read_a   = (RDW_MODE == 1) ? merged_a : old_a;
  assign read_b   = (RDW_MODE == 1) ? merged_b : old_b;

  // Port B lanes are written first so port A wins any byte both ports write in a collision
  always_ff @(posedge clock) begin
    if (clearing) begin
      mem[clear_count] <= '0;
    end else begin
      for (int i = 0; i < NB; i++)
        if (accept_b && write_enable_b[i]) mem[address_b][8*i +: 8] <= input_data_b[8*i +: 8];
      for (int i = 0; i < NB; i++)
        if (accept_a && write_enable_a[i]) mem[address_a][8*i +: 8] <= input_data_a[8*i +: 8];
    end
  end

`ifdef BRAM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] par_old_a, par_old_b, par_new_a, par_new_b, par_read_a, par_read_b;
  logic          parity_bad_a, parity_bad_b;

  function automatic logic [NB-1:0] byte_parity(input logic [RAM_WIDTH-1:0] word);
    for (int i = 0; i < NB; i++) byte_parity[i] = ^word[8*i +: 8];
  endfunction

  assign par_old_a    = par_mem[address_a];
  assign par_old_b    = par_mem[address_b];
  assign par_new_a    = byte_parity(input_data_a) ^ {NB{parity_inject}};
  assign par_new_b    = byte_parity(input_data_b) ^ {NB{parity_inject}};
  assign par_read_a   = (RDW_MODE == 1) ? ((par_old_a & ~write_enable_a) | (par_new_a & write_enable_a))
                                        : par_old_a;
  assign par_read_b   = (RDW_MODE == 1) ? ((par_old_b & ~write_enable_b) | (par_new_b & write_enable_b))
                                        : par_old_b;
  assign parity_bad_a = |(byte_parity(read_a) ^ par_read_a);
  assign parity_bad_b = |(byte_parity(read_b) ^ par_read_b);

  always_ff @(posedge clock) begin
    if (clearing) begin
      par_mem[clear_count] <= '0;
    end else begin
      for (int i = 0; i < NB; i++)
        if (accept_b && write_enable_b[i]) par_mem[address_b][i] <= par_new_b[i];
      for (int i = 0; i < NB; i++)
        if (accept_a && write_enable_a[i]) par_mem[address_a][i] <= par_new_a[i];
    end
  end
`endif

  logic                 valid_a1, valid_b1;
  logic [RAM_WIDTH-1:0] data_a1, data_b1;
`ifdef BRAM_PARITY_EN
  logic                 perr_a1, perr_b1;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_a1 <= 1'b0;
      valid_b1 <= 1'b0;
      data_a1  <= '0;
      data_b1  <= '0;
`ifdef BRAM_PARITY_EN
      perr_a1  <= 1'b0;
      perr_b1  <= 1'b0;
`endif
    end else begin
      valid_a1 <= accept_a;
      valid_b1 <= accept_b;
      if (accept_a) data_a1 <= read_a;
      if (accept_b) data_b1 <= read_b;
`ifdef BRAM_PARITY_EN
      perr_a1  <= accept_a && parity_bad_a;
      perr_b1  <= accept_b && parity_bad_b;
`endif
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                 valid_a2, valid_b2;
    logic [RAM_WIDTH-1:0] data_a2, data_b2;
`ifdef BRAM_PARITY_EN
    logic                 perr_a2, perr_b2;
`endif

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        valid_a2 <= 1'b0;
        valid_b2 <= 1'b0;
        data_a2  <= '0;
        data_b2  <= '0;
`ifdef BRAM_PARITY_EN
        perr_a2  <= 1'b0;
        perr_b2  <= 1'b0;
`endif
      end else begin
        valid_a2 <= valid_a1;
        valid_b2 <= valid_b1;
        if (valid_a1) data_a2 <= data_a1;
        if (valid_b1) data_b2 <= data_b1;
`ifdef BRAM_PARITY_EN
        perr_a2  <= perr_a1;
        perr_b2  <= perr_b1;
`endif
      end
    end

    assign valid_a       = valid_a2;
    assign valid_b       = valid_b2;
    assign output_data_a = data_a2;
    assign output_data_b = data_b2;
`ifdef BRAM_PARITY_EN
    assign parity_error_a = perr_a2;
    assign parity_error_b = perr_b2;
`endif
  end else begin : g_lat1
    assign valid_a       = valid_a1;
    assign valid_b       = valid_b1;
    assign output_data_a = data_a1;
    assign output_data_b = data_b1;
`ifdef BRAM_PARITY_EN
    assign parity_error_a = perr_a1;
    assign parity_error_b = perr_b1;
`endif
  end

endmodule

// File: tb/tb_bram_dual_port.sv
// Randomised bench for bram_dual_port: two instances (latency 1 / READ_FIRST and
// latency 2 / WRITE_FIRST) share stimulus and are checked against a word-array model.
module tb_bram_dual_port;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int HMAX  = 2048;

  logic          clock = 1'b0;
  logic          reset;
  logic          ena, enb;
  logic [3:0]    wea, web;
  logic [AW-1:0] aa, ab;
  logic [31:0]   dina, dinb;
  logic          busy0, busy1, v0a, v0b, v1a, v1b;
  logic [31:0]   out0_a, out0_b, out1_a, out1_b;
`ifdef BRAM_PARITY_EN
  logic          inject;
  logic          pe0a, pe0b, pe1a, pe1b;
`endif

  always #5 clock = ~clock;

  bram_dual_port #(.RAM_WIDTH(32), .RAM_ADDR_BITS(AW), .READ_LATENCY(1), .RDW_MODE(0)) dut0 (
    .clock(clock), .reset(reset), .busy(busy0),
    .enable_a(ena), .write_enable_a(wea), .address_a(aa), .input_data_a(dina),
    .output_data_a(out0_a), .valid_a(v0a),
`ifdef BRAM_PARITY_EN
    .parity_inject(inject), .parity_error_a(pe0a), .parity_error_b(pe0b),
`endif
    .enable_b(enb), .write_enable_b(web), .address_b(ab), .input_data_b(dinb),
    .output_data_b(out0_b), .valid_b(v0b)
  );

  bram_dual_port #(.RAM_WIDTH(32), .RAM_ADDR_BITS(AW), .READ_LATENCY(2), .RDW_MODE(1)) dut1 (
    .clock(clock), .reset(reset), .busy(busy1),
    .enable_a(ena), .write_enable_a(wea), .address_a(aa), .input_data_a(dina),
    .output_data_a(out1_a), .valid_a(v1a),
`ifdef BRAM_PARITY_EN
    .parity_inject(inject), .parity_error_a(pe1a), .parity_error_b(pe1b),
`endif
    .enable_b(enb), .write_enable_b(web), .address_b(ab), .input_data_b(dinb),
    .output_data_b(out1_b), .valid_b(v1b)
  );

  int total = 0;
  int bad   = 0;

  // Model: memory contents, cycles of clear remaining, and per-request read results by edge index
  logic [31:0] mem_m [DEPTH];
  int          clear_left;
  int          n;
  bit          acc_h [2][HMAX];
  logic [31:0] rd0_h [2][HMAX];
  logic [31:0] rd1_h [2][HMAX];
  logic [31:0] last0 [2];
  logic [31:0] last1 [2];
`ifdef BRAM_PARITY_EN
  logic [3:0]  par_m [DEPTH];
  bit          pe0_h [2][HMAX];
  bit          pe1_h [2][HMAX];
`endif

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mergeWord(input logic [31:0] old, input logic [31:0] din,
                                            input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = din[8*b +: 8];
    return r;
  endfunction

`ifdef BRAM_PARITY_EN
  function automatic logic [3:0] parityBits(input logic [31:0] w);
    logic [3:0] r;
    for (int b = 0; b < 4; b++) r[b] = ^w[8*b +: 8];
    return r;
  endfunction
`endif

  task automatic recordPort(input int p, input bit acc, input logic [AW-1:0] addr,
                            input logic [31:0] din, input logic [3:0] we);
    logic [31:0] old;
    old = mem_m[addr];
    acc_h[p][n] = acc;
    rd0_h[p][n] = old;
    rd1_h[p][n] = mergeWord(old, din, we);
`ifdef BRAM_PARITY_EN
    begin
      logic [3:0] newPar;
      newPar = (par_m[addr] & ~we) | ((parityBits(din) ^ {4{inject}}) & we);
      pe0_h[p][n] = acc && (parityBits(old) != par_m[addr]);
      pe1_h[p][n] = acc && (parityBits(rd1_h[p][n]) != newPar);
    end
`endif
  endtask

  task automatic writeModel(input logic [AW-1:0] addr, input logic [31:0] din, input logic [3:0] we);
    mem_m[addr] = mergeWord(mem_m[addr], din, we);
`ifdef BRAM_PARITY_EN
    par_m[addr] = (par_m[addr] & ~we) | ((parityBits(din) ^ {4{inject}}) & we);
`endif
  endtask

  task automatic checkAll();
    bit          ev0, ev1;
    logic [31:0] g0d, g1d;
    logic        g0v, g1v;
    checkOutput("busy0", {31'b0, busy0}, {31'b0, clear_left > 0});
    checkOutput("busy1", {31'b0, busy1}, {31'b0, clear_left > 0});
    for (int p = 0; p < 2; p++) begin
      ev0 = acc_h[p][n];
      if (ev0) last0[p] = rd0_h[p][n];
      ev1 = (n >= 2) && acc_h[p][n-1];
      if (ev1) last1[p] = rd1_h[p][n-1];
      g0d = p ? out0_b : out0_a;
      g0v = p ? v0b : v0a;
      g1d = p ? out1_b : out1_a;
      g1v = p ? v1b : v1a;
      checkOutput($sformatf("d0_p%0d_valid", p), {31'b0, g0v}, {31'b0, ev0});
      checkOutput($sformatf("d0_p%0d_data", p), g0d, last0[p]);
      checkOutput($sformatf("d1_p%0d_valid", p), {31'b0, g1v}, {31'b0, ev1});
      checkOutput($sformatf("d1_p%0d_data", p), g1d, last1[p]);
`ifdef BRAM_PARITY_EN
      checkOutput($sformatf("d0_p%0d_perr", p), {31'b0, p ? pe0b : pe0a}, {31'b0, ev0 && pe0_h[p][n]});
      checkOutput($sformatf("d1_p%0d_perr", p), {31'b0, p ? pe1b : pe1a},
                  {31'b0, ev1 && pe1_h[p][n-1]});
`endif
    end
  endtask

  // One cycle: drive at negedge, model the edge, check at the following negedge
  task automatic applyStimulus(input bit ea, input logic [3:0] wa, input logic [AW-1:0] addra,
                               input logic [31:0] da, input bit eb, input logic [3:0] wb,
                               input logic [AW-1:0] addrb, input logic [31:0] db);
    bit accA, accB;
    ena = ea; wea = wa; aa = addra; dina = da;
    enb = eb; web = wb; ab = addrb; dinb = db;
    accA = ea && (clear_left == 0);
    accB = eb && (clear_left == 0);
    n++;
    if (n >= HMAX) begin
      $display("[TB] FAIL history_overflow got=%0d expected<%0d", n, HMAX);
      $fatal(1, "[TB] history overflow");
    end
    recordPort(0, accA, addra, da, wa);
    recordPort(1, accB, addrb, db, wb);
    @(posedge clock);
    if (clear_left > 0) clear_left--;
    if (accB) writeModel(addrb, db, wb);
    if (accA) writeModel(addra, da, wa);
    @(negedge clock);
    checkAll();
  endtask

  task automatic idleCycle();
    applyStimulus(0, 4'h0, '0, 32'h0, 0, 4'h0, '0, 32'h0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    ena = 0; enb = 0; wea = 0; web = 0; aa = '0; ab = '0; dina = 0; dinb = 0;
    #1;
    checkOutput("rst_busy0", {31'b0, busy0}, 32'd1);
    checkOutput("rst_busy1", {31'b0, busy1}, 32'd1);
    checkOutput("rst_valids", {28'b0, v0a, v0b, v1a, v1b}, 32'd0);
    checkOutput("rst_out0a", out0_a, 32'h0);
    checkOutput("rst_out1b", out1_b, 32'h0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      mem_m[i] = '0;
`ifdef BRAM_PARITY_EN
      par_m[i] = '0;
`endif
    end
    clear_left = DEPTH;
    n = 0;
    last0[0] = '0; last0[1] = '0; last1[0] = '0; last1[1] = '0;
  endtask

  task automatic randomCycle();
    logic [3:0] wa, wb;
    wa = $urandom_range(0, 1) ? 4'($urandom_range(0, 15)) : 4'h0;
    wb = $urandom_range(0, 1) ? 4'($urandom_range(0, 15)) : 4'h0;
    applyStimulus(1'($urandom_range(0, 1)), wa, AW'($urandom_range(0, DEPTH-1)), $urandom,
                  1'($urandom_range(0, 1)), wb, AW'($urandom_range(0, DEPTH-1)), $urandom);
  endtask

  initial begin
`ifdef BRAM_PARITY_EN
    inject = 1'b0;
`endif
    doReset();

    // Clear interrupted at cycle 9 with requests that must be ignored, then a full sweep
    repeat (9) randomCycle();
    doReset();
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1, 4'hF, AW'(i), 32'hDEAD0000 + i, 1, 4'hF, AW'(DEPTH-1-i), 32'hBEEF0000 + i);
    checkOutput("clear_done_busy", {31'b0, busy0}, 32'd0);

    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1, 4'h0, AW'(i), 32'h0, 1, 4'h0, AW'(DEPTH-1-i), 32'h0);
    idleCycle();

    // Byte enables
    applyStimulus(1, 4'hF, 4'd3, 32'hAABBCCDD, 0, 4'h0, '0, 32'h0);
    applyStimulus(1, 4'h5, 4'd3, 32'h11223344, 0, 4'h0, '0, 32'h0);
    applyStimulus(1, 4'h0, 4'd3, 32'h0, 0, 4'h0, '0, 32'h0);
    checkOutput("ben_lat1", out0_a, 32'hAA22CC44);
    idleCycle();
    checkOutput("ben_lat2", out1_a, 32'hAA22CC44);

    // Same-port read-during-write
    applyStimulus(1, 4'hF, 4'd5, 32'h1, 0, 4'h0, '0, 32'h0);
    applyStimulus(1, 4'hF, 4'd5, 32'h2, 0, 4'h0, '0, 32'h0);
    checkOutput("rdw_read_first", out0_a, 32'h1);
    idleCycle();
    checkOutput("rdw_write_first", out1_a, 32'h2);

    // Cross-port collisions
    applyStimulus(1, 4'hF, 4'd7, 32'h000000FF, 1, 4'hF, 4'd7, 32'hFFFFFF00);
    applyStimulus(1, 4'h0, 4'd7, 32'h0, 0, 4'h0, '0, 32'h0);
    checkOutput("coll_ww", out0_a, 32'h000000FF);
    applyStimulus(1, 4'h0, 4'd8, 32'h0, 1, 4'hF, 4'd8, 32'h5);
    checkOutput("coll_rw_old", out0_a, 32'h0);
    idleCycle();
    checkOutput("coll_rw_old_lat2", out1_a, 32'h0);
    applyStimulus(1, 4'h0, 4'd8, 32'h0, 0, 4'h0, '0, 32'h0);
    checkOutput("coll_rw_new", out0_a, 32'h5);

    repeat (400) randomCycle();

    // Reset with live data, then confirm the sweep zeroed everything
    doReset();
    repeat (DEPTH) randomCycle();
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1, 4'h0, AW'(i), 32'h0, 1, 4'h0, AW'(i), 32'h0);
    checkOutput("reclear_last", out0_b, 32'h0);

`ifdef BRAM_PARITY_EN
    inject = 1'b1;
    applyStimulus(1, 4'hF, 4'd2, 32'h01020304, 0, 4'h0, '0, 32'h0);
    inject = 1'b0;
    applyStimulus(1, 4'h0, 4'd2, 32'h0, 0, 4'h0, '0, 32'h0);
    checkOutput("par_inject_err", {31'b0, pe0a}, 32'd1);
    applyStimulus(1, 4'hF, 4'd2, 32'h01020304, 0, 4'h0, '0, 32'h0);
    applyStimulus(1, 4'h0, 4'd2, 32'h0, 0, 4'h0, '0, 32'h0);
    checkOutput("par_clean", {31'b0, pe0a}, 32'd0);
    repeat (100) begin
      inject = 1'($urandom_range(0, 3) == 0);
      randomCycle();
    end
    inject = 1'b0;
`endif

    idleCycle();
    idleCycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
